// File: rtl/adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adder_pkg;

    // Default operand/result width of the adder.
    localparam int ADDER_WIDTH = 8;

    // Legal range for the WIDTH parameter.
    localparam int ADDER_WIDTH_MIN = 2;
    localparam int ADDER_WIDTH_MAX = 32;

    // Bit positions inside the packed flag bus {zero, overflow, carry}.
    localparam int FLAG_CARRY_IDX = 0;
    localparam int FLAG_OVF_IDX   = 1;
    localparam int FLAG_ZERO_IDX  = 2;
    localparam int FLAG_W         = 3;

    typedef logic [FLAG_W-1:0] flags_t;

    // Signed overflow: both addends share a sign and the sum sign differs from it.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // Pack the three status bits into the flag bus.
    function automatic flags_t pack_flags(input logic zero, input logic ovf, input logic carry);
        flags_t f;
        f                 = '0;
        f[FLAG_ZERO_IDX]  = zero;
        f[FLAG_OVF_IDX]   = ovf;
        f[FLAG_CARRY_IDX] = carry;
        return f;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the ripple-carry chain.
// Latency: purely combinational.
// Backpressure: none.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic half_sum;

    // Sum and carry from the classic two-half-adder decomposition.
    always_comb begin
        half_sum = a ^ b;
        s        = half_sum ^ cin;
        cout     = (a & b) | (cin & half_sum);
    end

endmodule

// File: rtl/adder_8b.sv
// Registered two-operand adder with carry, signed-overflow and zero flags.
// Latency: 1 cycle from in_valid to out_valid; full throughput.
// Backpressure: none; outputs hold their last value while in_valid is low.
module adder_8b
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] operand0,
    input  logic [WIDTH-1:0] operand1,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             out_valid
);

    // Ripple-carry chain: carry_chain[i] feeds bit i, carry_chain[WIDTH] is the carry-out.
    logic [WIDTH:0]   carry_chain;
    logic [WIDTH-1:0] sum_comb;
    flags_t           flags_comb;

    assign carry_chain[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_fa
            full_adder u_fa (
                .a    (operand0[gi]),
                .b    (operand1[gi]),
                .cin  (carry_chain[gi]),
                .s    (sum_comb[gi]),
                .cout (carry_chain[gi+1])
            );
        end
    endgenerate

    // Status flags derived from the truncated combinational sum.
    always_comb begin
        flags_comb = pack_flags(
            (sum_comb == '0),
            signed_ovf(operand0[WIDTH-1], operand1[WIDTH-1], sum_comb[WIDTH-1]),
            carry_chain[WIDTH]
        );
    end

    // Output register stage state.
    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flags_q,  flags_d;
    logic             out_valid_q, out_valid_d;

    // Capture a new sum only on valid operands; otherwise hold so idle-bus garbage never leaks out.
    always_comb begin
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            result_d = sum_comb;
            flags_d  = flags_comb;
        end
    end

    // Output flops, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign carry     = flags_q[FLAG_CARRY_IDX];
    assign overflow  = flags_q[FLAG_OVF_IDX];
    assign zero      = flags_q[FLAG_ZERO_IDX];
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_8b.sv
// Directed self-checking bench for adder_8b (8-bit and 4-bit instances).
// Latency: checks sampled on the falling edge after each active edge.
// Backpressure: none exercised.
module tb_adder_8b;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] operand0, operand1;
    logic [7:0] result;
    logic       carry, overflow, zero, out_valid;

    logic       w4_in_valid;
    logic [3:0] w4_op0, w4_op1;
    logic [3:0] w4_result;
    logic       w4_carry, w4_overflow, w4_zero, w4_out_valid;

    int checks = 0;
    int errors = 0;

    adder_8b #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .operand0  (operand0),
        .operand1  (operand1),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .out_valid (out_valid)
    );

    adder_8b #(.WIDTH(4)) dut_w4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w4_in_valid),
        .operand0  (w4_op0),
        .operand1  (w4_op1),
        .result    (w4_result),
        .carry     (w4_carry),
        .overflow  (w4_overflow),
        .zero      (w4_zero),
        .out_valid (w4_out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive operands, let one rising edge pass, return on the following falling edge.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic v);
        operand0 = a;
        operand1 = b;
        in_valid = v;
        @(negedge clk);
    endtask

    task automatic chk8(input string tag, input logic [7:0] r, input logic c,
                        input logic o, input logic z, input logic v);
        chk({tag, "_result"}, 32'(result), 32'(r));
        chk({tag, "_carry"}, 32'(carry), 32'(c));
        chk({tag, "_ovf"}, 32'(overflow), 32'(o));
        chk({tag, "_zero"}, 32'(zero), 32'(z));
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [8:0] rsum;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        operand0    = '0;
        operand1    = '0;
        w4_in_valid = 1'b0;
        w4_op0      = '0;
        w4_op1      = '0;

        // Reset state
        #12;
        chk8("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("w4_reset_valid", 32'(w4_out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add plus 4-bit wrap on the narrow instance
        w4_op0      = 4'hF;
        w4_op1      = 4'h1;
        w4_in_valid = 1'b1;
        step(8'd5, 8'd6, 1'b1);
        chk8("basic_5p6", 8'd11, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("w4_wrap_result", 32'(w4_result), 32'h0);
        chk("w4_wrap_carry", 32'(w4_carry), 32'd1);
        chk("w4_wrap_zero", 32'(w4_zero), 32'd1);
        chk("w4_wrap_ovf", 32'(w4_overflow), 32'd0);
        chk("w4_wrap_valid", 32'(w4_out_valid), 32'd1);
        w4_op0 = 4'h7;
        w4_op1 = 4'h1;
        step(8'd5, 8'd6, 1'b1);
        chk("w4_ovf_result", 32'(w4_result), 32'h8);
        chk("w4_ovf_flag", 32'(w4_overflow), 32'd1);
        chk("w4_ovf_carry", 32'(w4_carry), 32'd0);
        w4_in_valid = 1'b0;

        // Asynchronous reset in the middle of a cycle
        in_valid = 1'b1;
        operand0 = 8'd50;
        operand1 = 8'd60;
        #2;
        rst_n = 1'b0;
        #1;
        chk8("async_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk8("reset_held", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(8'd3, 8'd4, 1'b1);
        chk8("post_reset_3p4", 8'd7, 1'b0, 1'b0, 1'b0, 1'b1);

        // Unsigned wrap
        step(8'hFF, 8'h01, 1'b1);
        chk8("wrap_ff_01", 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        step(8'hFF, 8'hFF, 1'b1);
        chk8("wrap_ff_ff", 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1);

        // Signed overflow
        step(8'h7F, 8'h01, 1'b1);
        chk8("ovf_7f_01", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
        step(8'h80, 8'h80, 1'b1);
        chk8("ovf_80_80", 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        step(8'h80, 8'hFF, 1'b1);
        chk8("ovf_80_ff", 8'h7F, 1'b1, 1'b1, 1'b0, 1'b1);
        step(8'hC0, 8'hC0, 1'b1);
        chk8("neg_no_ovf", 8'h80, 1'b1, 1'b0, 1'b0, 1'b1);

        // Hold behaviour with stale operands on an idle bus
        step(8'd10, 8'd20, 1'b1);
        chk8("hold_load", 8'd30, 1'b0, 1'b0, 1'b0, 1'b1);
        step(8'd99, 8'd1, 1'b0);
        chk8("hold_idle", 8'd30, 1'b0, 1'b0, 1'b0, 1'b0);
        step(8'hFF, 8'h01, 1'b0);
        chk8("hold_idle2", 8'd30, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random operands in 0..127, back-to-back
        for (int i = 0; i < 200; i++) begin
            ra   = 8'($urandom_range(0, 127));
            rb   = 8'($urandom_range(0, 127));
            rsum = {1'b0, ra} + {1'b0, rb};
            step(ra, rb, 1'b1);
            chk("rand_result", 32'(result), 32'(rsum[7:0]));
            chk("rand_carry", 32'(carry), 32'd0);
            chk("rand_valid", 32'(out_valid), 32'd1);
            chk("rand_zero", 32'(zero), 32'(rsum[7:0] == 8'd0));
        end

        step(8'd0, 8'd0, 1'b0);
        chk("final_valid_low", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_8b.md
Name: adder_8b

Overview:
- Registered two-operand unsigned/two's-complement adder, default 8 bits wide.
- Sum is computed combinationally by a ripple-carry chain of full-adder cells, then captured in an output register.
- Provides the sum plus carry, signed-overflow and zero flags to downstream datapath logic.
- Standalone arithmetic leaf; no handshake back-pressure.

Parameters:
- WIDTH, 8, operand and result bit width (legal 2..32).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid this cycle.
- operand0  input  WIDTH  first addend.
- operand1  input  WIDTH  second addend.
- result  output  WIDTH  registered sum, modulo 2^WIDTH.
- carry  output  1  registered carry-out of the MSB (unsigned overflow).
- overflow  output  1  registered signed overflow.
- zero  output  1  registered flag, 1 when result == 0.
- out_valid  output  1  result/flags valid.

Behaviour:
- One clock domain. All outputs are flops on the clk rising edge, asynchronously cleared by rst_n low.
- Reset values: result=0, carry=0, overflow=0, zero=0, out_valid=0.
- No carry-in; the chain LSB carry-in is tied 0.
- Combinational sum: {c_out, s} = operand0 + operand1, built as WIDTH full-adder instances chained LSB to MSB.
- Overflow rule: overflow = (operand0[MSB] == operand1[MSB]) && (s[MSB] != operand0[MSB]).
- Zero rule: zero = (s == 0), evaluated on the truncated sum. 8'hFF+8'h01 therefore gives zero=1 with carry=1.
- Latency: exactly 1 cycle. Operands sampled on edge N with in_valid=1 appear on result/flags after edge N, with out_valid=1.
- in_valid=0 at an edge: out_valid goes 0 at that edge; result and flags hold their previous values (not recomputed).
- Back-to-back in_valid: full throughput, one result per cycle, no bubbles.
- Wrap-around: the sum is truncated to WIDTH bits. 8'hFF+8'hFF gives result=8'hFE, carry=1, overflow=0.
- Reset mid-operation: rst_n low clears all outputs immediately, independent of clk. The first valid after rst_n rises is computed normally.
- X/undefined operands while in_valid=0 must not alter the held outputs.

Decomposition:
- Shared package adder_pkg holds:
  - default width constant ADDER_WIDTH=8;
  - flag bit-index constants for a packed flag bus {zero, overflow, carry}.
- One sub-module, full_adder (a, b, cin -> s, cout), instantiated WIDTH times via generate.
- Top level adds the overflow/zero logic and the output register stage.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately; release and apply 8'd3+8'd4 valid -> next edge result=7, carry=0, overflow=0, zero=0, out_valid=1.
- Random unsigned range: 200 cycles, operands uniformly in 0..127 with in_valid=1 -> each cycle result equals the previous-cycle operand sum (max 254), carry=0, no bubbles.
- Unsigned wrap: 8'hFF+8'h01 -> result=0, carry=1, zero=1, overflow=0; 8'hFF+8'hFF -> 8'hFE, carry=1.
- Signed overflow: 8'h7F+8'h01 -> 8'h80, overflow=1, carry=0; 8'h80+8'h80 -> 8'h00, overflow=1, carry=1, zero=1.
- Hold behaviour: valid 8'd10+8'd20 then in_valid=0 with operands 8'd99+8'd1 -> result stays 30, out_valid=0 on the second edge.
- Parameter sweep: WIDTH=4, 4'hF+4'h1 -> result=0, carry=1, zero=1.
